boot_loader: RTL and testbench

- Upstream stage of the cpu core. After reset it copies a program image from an external byte-wide flash into the RAM's write port. When the copy is complete it asserts done, which drives the cpu's initialized flag.
- Image format in flash, starting at FLASH_BASE:
  - byte 0: length high byte
  - byte 1: length low byte
  - bytes 2..: payload, copied to RAM at LOAD_BASE.
- Fetch and execute do not start until done is high.

---
 rtl/boot_pkg.sv | 17 +
 rtl/boot_flash_if.sv | 45 ++++
 rtl/boot_loader.sv | 141 ++++++++++++++
 tb/tb_boot_loader.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared definitions for the boot loader: FSM state encoding and image header layout.
package boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ_HI   = 3'd1,
    ST_REQ_LO   = 3'd2,
    ST_CHECK    = 3'd3,
    ST_REQ_DATA = 3'd4,
    ST_WRITE    = 3'd5,
    ST_DONE     = 3'd6,
    ST_ERR      = 3'd7
  } boot_state_e;

  localparam int unsigned HDR_BYTES = 2;

endpackage

// File: rtl/boot_flash_if.sv
// Flash read handshake: turns a start/addr request into data_valid/data, and
// flags a timeout when flash_ack fails to arrive within TIMEOUT request cycles.
module boot_flash_if #(
  parameter int unsigned FLASH_AW = 16,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [FLASH_AW-1:0] addr,
  output logic                flash_req,
  output logic [FLASH_AW-1:0] flash_addr,
  input  logic                flash_ack,
  input  logic [7:0]          flash_data,
  output logic                data_valid,
  output logic [7:0]          data,
  output logic                timeout
);

  // The TIMEOUT-th unacknowledged request cycle is the one that gives up.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  logic [7:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    flash_req  = start;
    flash_addr = addr;
    data_valid = start & flash_ack;
    data       = flash_data;
    timeout    = start && !flash_ack && (wait_cnt_q == LAST_WAIT);
    wait_cnt_d = 8'd0;
    if (start && !flash_ack && !timeout) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= 8'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Copies a length-prefixed program image from byte-wide flash into RAM after reset,
// then holds done (or error) until the next reset.
module boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned FLASH_AW   = 16,
  parameter int unsigned RAM_AW     = 16,
  parameter int unsigned FLASH_BASE = 0,
  parameter int unsigned LOAD_BASE  = 0,
  parameter int unsigned RAM_DEPTH  = 4096,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                flash_req,
  output logic [FLASH_AW-1:0] flash_addr,
  input  logic                flash_ack,
  input  logic [7:0]          flash_data,
  output logic                ram_we,
  output logic [RAM_AW-1:0]   ram_addr,
  output logic [7:0]          ram_wdata,
  output logic                done,
  output logic                error,
  output logic [15:0]         byte_count
);

  localparam logic [FLASH_AW-1:0] HDR_ADDR  = FLASH_AW'(FLASH_BASE);
  localparam logic [FLASH_AW-1:0] DATA_ADDR = FLASH_AW'(FLASH_BASE + HDR_BYTES);
  localparam logic [RAM_AW-1:0]   LOAD_ADDR = RAM_AW'(LOAD_BASE);
  localparam logic [16:0]         LEN_LIMIT = 17'(RAM_DEPTH - LOAD_BASE);

  boot_state_e state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] byte_count_q, byte_count_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] count_inc;

  logic                req_start;
  logic [FLASH_AW-1:0] req_addr;
  logic                data_valid;
  logic [7:0]          rd_data;
  logic                timeout;

  boot_flash_if #(
    .FLASH_AW (FLASH_AW),
    .TIMEOUT  (TIMEOUT)
  ) u_flash_if (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (req_start),
    .addr       (req_addr),
    .flash_req  (flash_req),
    .flash_addr (flash_addr),
    .flash_ack  (flash_ack),
    .flash_data (flash_data),
    .data_valid (data_valid),
    .data       (rd_data),
    .timeout    (timeout)
  );

  assign count_inc = byte_count_q + 16'd1;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    byte_count_d = byte_count_q;
    data_d       = data_q;
    req_start    = 1'b0;
    req_addr     = HDR_ADDR;
    ram_we       = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_REQ_HI;
      ST_REQ_HI: begin
        req_start = 1'b1;
        if (data_valid) begin
          len_d[15:8] = rd_data;
          state_d     = ST_REQ_LO;
        end else if (timeout) begin
          state_d = ST_ERR;
        end
      end
      ST_REQ_LO: begin
        req_start = 1'b1;
        req_addr  = HDR_ADDR + FLASH_AW'(1);
        if (data_valid) begin
          len_d[7:0] = rd_data;
          state_d    = ST_CHECK;
        end else if (timeout) begin
          state_d = ST_ERR;
        end
      end
      // Length compare is widened to 17 bits so a full 64K limit cannot wrap.
      ST_CHECK: begin
        if (len_q == 16'd0) begin
          state_d = ST_DONE;
        end else if ({1'b0, len_q} > LEN_LIMIT) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_REQ_DATA;
        end
      end
      ST_REQ_DATA: begin
        req_start = 1'b1;
        req_addr  = DATA_ADDR + FLASH_AW'(byte_count_q);
        if (data_valid) begin
          data_d  = rd_data;
          state_d = ST_WRITE;
        end else if (timeout) begin
          state_d = ST_ERR;
        end
      end
      ST_WRITE: begin
        ram_we       = 1'b1;
        byte_count_d = count_inc;
        state_d      = (count_inc == len_q) ? ST_DONE : ST_REQ_DATA;
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      len_q        <= 16'd0;
      byte_count_q <= 16'd0;
      data_q       <= 8'd0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      byte_count_q <= byte_count_d;
      data_q       <= data_d;
    end
  end

  assign ram_addr   = LOAD_ADDR + RAM_AW'(byte_count_q);
  assign ram_wdata  = data_q;
  assign done       = (state_q == ST_DONE);
  assign error      = (state_q == ST_ERR);
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: a flash model with configurable wait states and
// a per-cycle timeline model of the expected load, plus literal pins per scenario.
module tb_boot_loader;

  localparam int TIMEOUT_C = 255;
  localparam int DEPTH_C   = 4096;
  localparam int NCYC      = 8400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flash_req;
  logic [15:0] flash_addr;
  logic        flash_ack;
  logic [7:0]  flash_data;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        done;
  logic        error;
  logic [15:0] byte_count;

  int errors = 0;
  int checks = 0;

  boot_loader #(
    .FLASH_AW   (16),
    .RAM_AW     (16),
    .FLASH_BASE (0),
    .LOAD_BASE  (0),
    .RAM_DEPTH  (DEPTH_C),
    .TIMEOUT    (TIMEOUT_C)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flash_req  (flash_req),
    .flash_addr (flash_addr),
    .flash_ack  (flash_ack),
    .flash_data (flash_data),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .done       (done),
    .error      (error),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  // Flash model: acks after wait_states extra request cycles, never acks stall_addr.
  logic [7:0] flash_mem [0:65535];
  int         wait_states = 0;
  bit         stall_en = 1'b0;
  logic [15:0] stall_addr = 16'd0;
  int         wcnt = 0;

  assign flash_data = flash_mem[flash_addr];
  assign flash_ack  = flash_req && (wcnt >= wait_states) && !(stall_en && flash_addr == stall_addr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wcnt <= 0;
    else if (!flash_req || flash_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  // Expected timeline, indexed by rising edges seen since reset release.
  bit          exp_req   [NCYC];
  logic [15:0] exp_faddr [NCYC];
  bit          exp_we    [NCYC];
  logic [15:0] exp_waddr [NCYC];
  logic [7:0]  exp_wdata [NCYC];
  bit          exp_done  [NCYC];
  bit          exp_err   [NCYC];
  int          exp_bc    [NCYC];
  int          model_end;

  // Per-run observations used by the literal pins.
  int          we_count, first_done, first_err;
  logic [15:0] first_waddr, last_waddr;
  logic [7:0]  first_wdata, last_wdata;
  bit          saw_addr2;
  bit          prev_req, prev_ack;
  logic [15:0] prev_addr;

  task automatic cmp(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (cycle %0d): got %0h, expected %0h", name, c, act, exp);
    end
  endtask

  task automatic markReq(input int s, input int n, input int addr);
    for (int k = s; k < s + n && k < NCYC; k++) begin
      exp_req[k]   = 1'b1;
      exp_faddr[k] = 16'(addr);
    end
  endtask

  task automatic buildModel(input int w, input int stall_idx);
    int  s, len, running;
    bit  stalled;
    for (int c = 0; c < NCYC; c++) begin
      exp_req[c] = 0; exp_faddr[c] = '0; exp_we[c] = 0; exp_waddr[c] = '0;
      exp_wdata[c] = '0; exp_done[c] = 0; exp_err[c] = 0; exp_bc[c] = 0;
    end
    len = {flash_mem[0], flash_mem[1]};
    stalled = 1'b0;
    s = 1;
    markReq(s, w + 1, 0); s += w + 1;
    markReq(s, w + 1, 1); s += w + 1;
    s += 1;
    if (len == 0) begin
      for (int c = s; c < NCYC; c++) exp_done[c] = 1'b1;
    end else if (len > DEPTH_C) begin
      for (int c = s; c < NCYC; c++) exp_err[c] = 1'b1;
    end else begin
      for (int i = 0; i < len && !stalled; i++) begin
        if (i == stall_idx) begin
          markReq(s, TIMEOUT_C, 2 + i);
          s += TIMEOUT_C;
          for (int c = s; c < NCYC; c++) exp_err[c] = 1'b1;
          stalled = 1'b1;
        end else begin
          markReq(s, w + 1, 2 + i);
          s += w + 1;
          if (s < NCYC) begin
            exp_we[s]    = 1'b1;
            exp_waddr[s] = 16'(i);
            exp_wdata[s] = flash_mem[2 + i];
          end
          s += 1;
        end
      end
      if (!stalled) for (int c = s; c < NCYC; c++) exp_done[c] = 1'b1;
    end
    running = 0;
    for (int c = 0; c < NCYC; c++) begin
      exp_bc[c] = running;
      if (exp_we[c]) running++;
    end
    model_end = s;
  endtask

  task automatic checkReset(input string tag);
    cmp({tag, "_req"},   0, 32'(flash_req),  0);
    cmp({tag, "_faddr"}, 0, 32'(flash_addr), 0);
    cmp({tag, "_we"},    0, 32'(ram_we),     0);
    cmp({tag, "_waddr"}, 0, 32'(ram_addr),   0);
    cmp({tag, "_wdata"}, 0, 32'(ram_wdata),  0);
    cmp({tag, "_done"},  0, 32'(done),       0);
    cmp({tag, "_error"}, 0, 32'(error),      0);
    cmp({tag, "_bc"},    0, 32'(byte_count), 0);
  endtask

  task automatic checkOutput(input int c);
    cmp("flash_req", c, 32'(flash_req), 32'(exp_req[c]));
    if (exp_req[c]) cmp("flash_addr", c, 32'(flash_addr), 32'(exp_faddr[c]));
    cmp("ram_we", c, 32'(ram_we), 32'(exp_we[c]));
    if (exp_we[c]) begin
      cmp("ram_addr",  c, 32'(ram_addr),  32'(exp_waddr[c]));
      cmp("ram_wdata", c, 32'(ram_wdata), 32'(exp_wdata[c]));
    end
    cmp("done",       c, 32'(done),       32'(exp_done[c]));
    cmp("error",      c, 32'(error),      32'(exp_err[c]));
    cmp("byte_count", c, 32'(byte_count), 32'(exp_bc[c]));
    cmp("done_and_error", c, 32'(done & error), 0);
    cmp("we_with_req",    c, 32'(ram_we & flash_req), 0);
    if (prev_req && !prev_ack && flash_req) cmp("addr_stable", c, 32'(flash_addr), 32'(prev_addr));
    if (ram_we) begin
      we_count++;
      if (we_count == 1) begin
        first_waddr = ram_addr;
        first_wdata = ram_wdata;
      end
      last_waddr = ram_addr;
      last_wdata = ram_wdata;
    end
    if (done && first_done < 0) first_done = c;
    if (error && first_err < 0) first_err = c;
    if (flash_req && flash_addr == 16'd2) saw_addr2 = 1'b1;
    prev_req  = flash_req;
    prev_ack  = flash_ack;
    prev_addr = flash_addr;
  endtask

  // Holds reset, checks reset outputs, builds the model, then releases reset.
  task automatic applyStimulus(input int w, input int stall_idx, input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    wait_states = w;
    stall_en    = (stall_idx >= 0);
    stall_addr  = 16'(2 + stall_idx);
    repeat (2) @(negedge clk);
    checkReset({tag, "_rst"});
    buildModel(w, stall_idx);
    we_count = 0; first_done = -1; first_err = -1; saw_addr2 = 1'b0;
    first_waddr = '0; last_waddr = '0; first_wdata = '0; last_wdata = '0;
    prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic runLoad(input int stop_at);
    int last;
    last = (stop_at >= 0) ? stop_at : model_end + 3;
    if (last >= NCYC) last = NCYC - 1;
    for (int c = 0; c <= last; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      checkOutput(c);
    end
  endtask

  task automatic loadImage(input int len, input logic [7:0] seed);
    flash_mem[0] = 8'(len >> 8);
    flash_mem[1] = 8'(len);
    for (int i = 0; i < len && i < DEPTH_C + 1; i++) flash_mem[2 + i] = 8'(seed + 8'(i * 7));
  endtask

  initial begin
    $display("[TB] boot_loader bench start");

    flash_mem[0] = 8'h00; flash_mem[1] = 8'h04;
    flash_mem[2] = 8'hDE; flash_mem[3] = 8'hAD; flash_mem[4] = 8'hBE; flash_mem[5] = 8'hEF;
    applyStimulus(0, -1, "t1");
    runLoad(-1);
    cmp("t1_done_cycle",   0, 32'(first_done),  12);
    cmp("t1_byte_count",   0, 32'(byte_count),  4);
    cmp("t1_error",        0, 32'(error),       0);
    cmp("t1_we_count",     0, 32'(we_count),    4);
    cmp("t1_first_waddr",  0, 32'(first_waddr), 0);
    cmp("t1_first_wdata",  0, 32'(first_wdata), 32'h DE);
    cmp("t1_last_waddr",   0, 32'(last_waddr),  3);
    cmp("t1_last_wdata",   0, 32'(last_wdata),  32'h EF);

    flash_mem[0] = 8'h00; flash_mem[1] = 8'h02;
    flash_mem[2] = 8'h11; flash_mem[3] = 8'h22;
    applyStimulus(3, -1, "t2");
    runLoad(-1);
    cmp("t2_we_count",   0, 32'(we_count),   2);
    cmp("t2_done",       0, 32'(done),       1);
    cmp("t2_done_cycle", 0, 32'(first_done), 20);
    cmp("t2_last_wdata", 0, 32'(last_wdata), 32'h22);

    flash_mem[0] = 8'h00; flash_mem[1] = 8'h00;
    applyStimulus(0, -1, "t3");
    runLoad(-1);
    cmp("t3_we_count",   0, 32'(we_count),   0);
    cmp("t3_read_addr2", 0, 32'(saw_addr2),  0);
    cmp("t3_done_cycle", 0, 32'(first_done), 4);

    flash_mem[0] = 8'h10; flash_mem[1] = 8'h01;
    applyStimulus(0, -1, "t4");
    runLoad(-1);
    cmp("t4_err_cycle", 0, 32'(first_err), 4);
    cmp("t4_we_count",  0, 32'(we_count),  0);
    cmp("t4_done",      0, 32'(done),      0);

    loadImage(4096, 8'h03);
    applyStimulus(0, -1, "t5");
    runLoad(-1);
    cmp("t5_we_count",   0, 32'(we_count),   4096);
    cmp("t5_last_waddr", 0, 32'(last_waddr), 32'h0FFF);
    cmp("t5_done_cycle", 0, 32'(first_done), 8196);
    cmp("t5_error",      0, 32'(error),      0);

    loadImage(4, 8'h40);
    applyStimulus(0, 2, "t6");
    runLoad(-1);
    cmp("t6_err_cycle",  0, 32'(first_err),  8 + TIMEOUT_C);
    cmp("t6_byte_count", 0, 32'(byte_count), 2);
    cmp("t6_flash_req",  0, 32'(flash_req),  0);
    cmp("t6_done",       0, 32'(done),       0);

    loadImage(8, 8'h90);
    applyStimulus(0, -1, "t7a");
    runLoad(13);
    cmp("t7_in_write",  13, 32'(ram_we),     1);
    cmp("t7_bc_before", 13, 32'(byte_count), 4);
    rst_n = 1'b0;
    #1;
    checkReset("t7_mid");
    applyStimulus(0, -1, "t7b");
    runLoad(-1);
    cmp("t7_we_count",    0, 32'(we_count),    8);
    cmp("t7_first_waddr", 0, 32'(first_waddr), 0);
    cmp("t7_first_wdata", 0, 32'(first_wdata), 32'h90);
    cmp("t7_last_waddr",  0, 32'(last_waddr),  7);
    cmp("t7_done_cycle",  0, 32'(first_done),  20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
